// File: rtl/ryuki_trace_buffer_if.sv
// Bundles the producer strobe, consumer handshake and status signals
// of the trace buffer.
// master: the side that feeds records and drains them (trace_unit plus consumer).
// slave: the buffer itself.
interface ryuki_trace_buffer_if #(
  parameter int DEPTH   = 16,
  parameter int DROP_W  = 16,
  parameter int TRACE_W = 32
);
  logic                     flush;
  logic                     trace_ready;
  logic [TRACE_W-1:0]       trace;
  logic                     out_valid;
  logic                     out_ready;
  logic [TRACE_W-1:0]       out_data;
  logic [$clog2(DEPTH):0]   level;
  logic                     full;
  logic                     overflow;
  logic [DROP_W-1:0]        drop_count;

  modport master (
    output flush, trace_ready, trace, out_ready,
    input  out_valid, out_data, level, full, overflow, drop_count
  );

  modport slave (
    input  flush, trace_ready, trace, out_ready,
    output out_valid, out_data, level, full, overflow, drop_count
  );
endinterface

// File: rtl/ryuki_trace_buffer.sv
// Elastic FIFO behind trace_unit. The producer can never be stalled, so
// records arriving while full are dropped and counted instead. The head
// record is presented first-word fall-through on a valid/ready handshake.
// TRACE_W is the width of one trace_output record.
module ryuki_trace_buffer #(
  parameter int DEPTH   = 16,
  parameter int DROP_W  = 16,
  parameter int TRACE_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  ryuki_trace_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [TRACE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level;
  logic [DROP_W-1:0]  drop_count;
  logic               overflow;

  logic full;
  logic pop;
  logic push_ok;
  logic drop;

  // A pop frees a slot in the same cycle, so a push into a full buffer
  // still succeeds when the consumer is draining.
  assign full    = (level == LVL_W'(DEPTH));
  assign pop     = (level != '0) && bus.out_ready;
  assign push_ok = bus.trace_ready && (!full || pop);
  assign drop    = bus.trace_ready && full && !pop;

  // Record storage is deliberately not reset; level alone says what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !bus.flush) begin
      mem[wr_ptr] <= bus.trace;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; occupancy is
  // tracked separately so full and empty are unambiguous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok && !pop) begin
        level <= level + LVL_W'(1);
      end else if (pop && !push_ok) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  // Saturating drop counter and sticky overflow flag; a flush clears both
  // and the record offered during a flush is not treated as a drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (bus.flush) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) begin
        drop_count <= drop_count + DROP_W'(1);
      end
    end
  end

  assign bus.out_valid  = (level != '0);
  assign bus.out_data   = mem[rd_ptr];
  assign bus.level      = level;
  assign bus.full       = full;
  assign bus.overflow   = overflow;
  assign bus.drop_count = drop_count;
endmodule

// File: tb/tb_ryuki_trace_buffer.sv
// Directed bench for ryuki_trace_buffer: reset, single record, fill and
// overflow, full push+pop, streaming wrap, flush, async reset and drop
// counter saturation with a narrow counter.
module tb_ryuki_trace_buffer;
  localparam int DEPTH   = 16;
  localparam int DROP_W  = 4;
  localparam int TRACE_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   max_level;

  ryuki_trace_buffer_if #(.DEPTH(DEPTH), .DROP_W(DROP_W), .TRACE_W(TRACE_W)) bus ();

  ryuki_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W), .TRACE_W(TRACE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10ns clock.
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, let one edge pass, sample point is edge+1.
  task automatic applyStimulus(input logic push, input logic [31:0] rec,
                               input logic ready, input logic flush);
    bus.trace_ready = push;
    bus.trace       = rec;
    bus.out_ready   = ready;
    bus.flush       = flush;
    @(posedge clk);
    #1;
    bus.trace_ready = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic fillFrom(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, base + 32'(i), 1'b0, 1'b0);
    end
  endtask

  initial begin
    bus.flush       = 1'b0;
    bus.trace_ready = 1'b0;
    bus.trace       = '0;
    bus.out_ready   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_level", 32'(bus.level), 32'd0);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("rst_drops", 32'(bus.drop_count), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single record with one-cycle latency, held stable while not ready
    applyStimulus(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    checkOutput("single_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("single_data", bus.out_data, 32'hA5A5_0001);
    checkOutput("single_level", 32'(bus.level), 32'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("single_hold", bus.out_data, 32'hA5A5_0001);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("single_pop_level", 32'(bus.level), 32'd0);
    checkOutput("single_pop_valid", 32'(bus.out_valid), 32'd0);

    // Fill with 20 records: 16 stored, 4 dropped
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
      if (i == 14) checkOutput("fill_not_full", 32'(bus.full), 32'd0);
      if (i == 15) checkOutput("fill_full", 32'(bus.full), 32'd1);
    end
    checkOutput("fill_level", 32'(bus.level), 32'd16);
    checkOutput("fill_drops", 32'(bus.drop_count), 32'd4);
    checkOutput("fill_overflow", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      checkOutput("fill_drain_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("fill_drain_data", bus.out_data, 32'(i));
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    end
    checkOutput("fill_empty_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("fill_empty_level", 32'(bus.level), 32'd0);

    // Full with simultaneous push and pop
    fillFrom(32'd100, 16);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    checkOutput("pp_level", 32'(bus.level), 32'd16);
    checkOutput("pp_drops", 32'(bus.drop_count), 32'd4);
    checkOutput("pp_full", 32'(bus.full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      checkOutput("pp_drain_data", bus.out_data, (i == 15) ? 32'hDEAD_BEEF : 32'd101 + 32'(i));
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    end
    checkOutput("pp_empty", 32'(bus.out_valid), 32'd0);

    // Streaming 100 records with the consumer always ready
    max_level = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 32'd1000 + 32'(i), 1'b1, 1'b0);
      if (int'(bus.level) > max_level) max_level = int'(bus.level);
      checkOutput("stream_data", bus.out_data, 32'd1000 + 32'(i));
    end
    checkOutput("stream_max_level", 32'(max_level), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("stream_drained", 32'(bus.level), 32'd0);
    checkOutput("stream_drops", 32'(bus.drop_count), 32'd4);

    // Flush: 5 records queued with 3 drops, then flush together with a push
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("flush0_drops", 32'(bus.drop_count), 32'd0);
    checkOutput("flush0_overflow", 32'(bus.overflow), 32'd0);
    fillFrom(32'd200, 19);
    checkOutput("flush_pre_drops", 32'(bus.drop_count), 32'd3);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    end
    checkOutput("flush_pre_level", 32'(bus.level), 32'd5);
    checkOutput("flush_pre_head", bus.out_data, 32'd211);
    applyStimulus(1'b1, 32'h0000_0BAD, 1'b0, 1'b1);
    checkOutput("flush_level", 32'(bus.level), 32'd0);
    checkOutput("flush_drops", 32'(bus.drop_count), 32'd0);
    checkOutput("flush_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("flush_valid", 32'(bus.out_valid), 32'd0);
    fillFrom(32'd400, 5);
    checkOutput("requeue_level", 32'(bus.level), 32'd5);
    checkOutput("requeue_head", bus.out_data, 32'd400);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("arst_level", 32'(bus.level), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("arst_after_valid", 32'(bus.out_valid), 32'd0);

    // Drop counter saturation at 15 with a 4-bit counter
    fillFrom(32'd500, 16);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'd600 + 32'(i), 1'b0, 1'b0);
      if (i == 13) checkOutput("sat_14", 32'(bus.drop_count), 32'd14);
      if (i == 14) checkOutput("sat_15", 32'(bus.drop_count), 32'd15);
    end
    checkOutput("sat_hold", 32'(bus.drop_count), 32'd15);
    checkOutput("sat_overflow", 32'(bus.overflow), 32'd1);
    checkOutput("sat_level", 32'(bus.level), 32'd16);
    checkOutput("sat_head", bus.out_data, 32'd500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
